// File: rtl/audio_i2s_tx_if.sv
// Sample-pair handshake between an audio source and the I2S transmitter.
interface audio_i2s_tx_if #(
  parameter int unsigned AUDIO_DW = 16
) ();
  logic [AUDIO_DW-1:0] sample_l;
  logic [AUDIO_DW-1:0] sample_r;
  logic                sample_valid;
  logic                sample_ready;

  modport master (
    output sample_l,
    output sample_r,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_l,
    input  sample_r,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/audio_i2s_tx.sv
// I2S / left-justified serial audio transmitter with a one-pair holding buffer,
// frame-boundary mute and underrun signalling.
module audio_i2s_tx #(
  parameter int unsigned AUDIO_DW  = 16,
  parameter int unsigned SLOT_BITS = 32,
  parameter int unsigned CLK_DIV   = 8,
  parameter int unsigned FMT       = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  audio_i2s_tx_if.slave smp,
  input  logic          mute,
  output logic          underrun,
  output logic          I2S_BCK,
  output logic          I2S_LRCK,
  output logic          I2S_DATA
);

  localparam int unsigned CNT_W    = $clog2(2 * SLOT_BITS);
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned LAST_BIT = 2 * SLOT_BITS - 1;
  localparam int unsigned MSB_OFF  = (FMT == 0) ? 1 : 0;

  logic [DIV_W-1:0]    div_q, div_d;
  logic                bck_q, bck_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic                lrck_q, lrck_d;
  logic                data_q, data_d;
  logic                underrun_q, underrun_d;
  logic                hold_full_q, hold_full_d;
  logic [AUDIO_DW-1:0] hold_l_q, hold_l_d;
  logic [AUDIO_DW-1:0] hold_r_q, hold_r_d;
  logic [AUDIO_DW-1:0] word_l_q, word_l_d;
  logic [AUDIO_DW-1:0] word_r_q, word_r_d;

  logic                tick;
  logic                fall;
  logic                frame_start;
  logic                accept;
  logic [CNT_W-1:0]    pos;
  logic [CNT_W-1:0]    idx;
  logic                in_range;
  logic [AUDIO_DW-1:0] active_word;
  logic [AUDIO_DW-1:0] shifted;

  // State register; reset aborts any frame in flight and drops the buffered pair.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q       <= '0;
      bck_q       <= 1'b0;
      bit_q       <= '0;
      lrck_q      <= 1'b0;
      data_q      <= 1'b0;
      underrun_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      word_l_q    <= '0;
      word_r_q    <= '0;
    end else begin
      div_q       <= div_d;
      bck_q       <= bck_d;
      bit_q       <= bit_d;
      lrck_q      <= lrck_d;
      data_q      <= data_d;
      underrun_q  <= underrun_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      word_l_q    <= word_l_d;
      word_r_q    <= word_r_d;
    end
  end

  always_comb begin
    div_d       = div_q;
    bck_d       = bck_q;
    bit_d       = bit_q;
    lrck_d      = lrck_q;
    data_d      = data_q;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    word_l_d    = word_l_q;
    word_r_d    = word_r_q;
    pos         = '0;
    idx         = '0;
    in_range    = 1'b0;
    active_word = '0;
    shifted     = '0;

    tick        = (div_q == DIV_W'(CLK_DIV - 1));
    fall        = tick && bck_q;
    frame_start = fall && (bit_q == CNT_W'(LAST_BIT));
    accept      = smp.sample_valid && !hold_full_q;
    underrun_d  = frame_start && !hold_full_q;

    div_d = tick ? '0 : div_q + DIV_W'(1);
    if (tick) begin
      bck_d = !bck_q;
    end

    // Frame boundary: take the buffered pair, else keep repeating the last word.
    if (frame_start) begin
      hold_full_d = 1'b0;
      if (hold_full_q) begin
        word_l_d = hold_l_q;
        word_r_d = hold_r_q;
      end
      if (mute) begin
        word_l_d = '0;
        word_r_d = '0;
      end
    end

    if (accept) begin
      hold_l_d    = smp.sample_l;
      hold_r_d    = smp.sample_r;
      hold_full_d = 1'b1;
    end

    // Serial outputs change only with BCK low-going so they are stable at its rise.
    if (fall) begin
      bit_d       = frame_start ? '0 : bit_q + CNT_W'(1);
      lrck_d      = (bit_d >= CNT_W'(SLOT_BITS));
      pos         = lrck_d ? (bit_d - CNT_W'(SLOT_BITS)) : bit_d;
      in_range    = (pos >= CNT_W'(MSB_OFF)) && (pos < CNT_W'(AUDIO_DW + MSB_OFF));
      idx         = CNT_W'(AUDIO_DW - 1 + MSB_OFF) - pos;
      active_word = lrck_d ? word_r_d : word_l_d;
      shifted     = active_word >> idx;
      data_d      = in_range && shifted[0];
    end
  end

  assign smp.sample_ready = !hold_full_q;
  assign underrun         = underrun_q;
  assign I2S_BCK          = bck_q;
  assign I2S_LRCK         = lrck_q;
  assign I2S_DATA         = data_q;

endmodule
